bram_arbiter_rv32: RTL

- Shares one single-port 32-bit BRAM bank (1-cycle registered read, byte write enables) between NUM_REQ bus masters, e.g. CPU data port plus host/DMA port.
- Pipelined round-robin arbiter: request stage, memory-access stage, response stage.
- Range-checks each address against BaseAddress..EndAddress and rebases it before driving the memory.
- Sits between the masters and the memory instance; memory keeps its own wrapper untouched.

---
 rtl/bram_arb_pkg.sv | 39 +++
 rtl/bram_rr_pick.sv | 35 +++
 rtl/bram_arbiter_rv32.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the round-robin BRAM arbiter.
// cmd_t is the command captured at the request stage; rr_next is the
// rotating-priority search used by bram_rr_pick.
package bram_arb_pkg;

   localparam int MAX_REQ = 4;
   localparam int IDX_W   = 2;
   // Command address field is sized for the widest supported requester
   // address; narrower addresses are zero-extended into it.
   localparam int MAX_AW  = 64;

   typedef struct packed {
      logic [MAX_AW-1:0] addr;
      logic [3:0]        wr;
      logic [31:0]       wdata;
      logic [IDX_W-1:0]  id;
   } cmd_t;

   // First eligible index searching upward from ptr+1, wrapping modulo n.
   // The pointer itself is visited last. Returns ptr when nothing is eligible.
   function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] elig,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int                 n);
      logic [IDX_W-1:0] win;
      logic [IDX_W-1:0] cand;
      logic             found;
      win   = ptr;
      found = 1'b0;
      for (int i = 1; i <= MAX_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % n);
         if (!found && (i <= n) && elig[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/bram_rr_pick.sv
// Round-robin picker: combinational winner selection plus the registered
// last-winner pointer.
// Ports: clk/reset; i_eligible (per-requester eligibility); o_vld (any
// winner), o_idx (winner index), o_ptr (current pointer = last winner).
module bram_rr_pick
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQ-1:0]  i_eligible,
   output logic                o_vld,
   output logic [IDX_W-1:0]    o_idx,
   output logic [IDX_W-1:0]    o_ptr
);

   logic [IDX_W-1:0]   r_ptr;
   logic [MAX_REQ-1:0] w_elig_ext;

   assign w_elig_ext = MAX_REQ'(i_eligible);
   assign o_vld      = |i_eligible;
   assign o_idx      = rr_next(w_elig_ext, r_ptr, NUM_REQ);
   assign o_ptr      = r_ptr;

   // Pointer only moves when someone actually wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (o_vld) begin
         r_ptr <= o_idx;
      end
   end

endmodule

// File: rtl/bram_arbiter_rv32.sv
// Pipelined round-robin arbiter sharing one single-port 32-bit BRAM between
// NUM_REQ masters: request stage -> memory-access stage -> response stage.
// Ports: req/addr/wr/wdata (packed per requester), gnt/rvalid/err pulses,
// broadcast rdata; mem_addr/mem_wen/mem_wdata/mem_rdata toward the BRAM.
// Optional macro BRAM_ARB_LOCK_EN adds the 'lock' input for bus locking.
module bram_arbiter_rv32
   import bram_arb_pkg::*;
#(
   parameter int                       NUM_REQ        = 2,
   parameter int                       address_width  = 32,
   parameter logic [address_width-1:0] BaseAddress    = '0,
   parameter logic [address_width-1:0] EndAddress     = '0,
   parameter int                       mem_addr_width = 16
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req,
`ifdef BRAM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]                lock,
`endif
   input  logic [NUM_REQ*address_width-1:0]  addr,
   input  logic [NUM_REQ*4-1:0]              wr,
   input  logic [NUM_REQ*32-1:0]             wdata,
   output logic [NUM_REQ-1:0]                gnt,
   output logic [NUM_REQ-1:0]                rvalid,
   output logic [NUM_REQ-1:0]                err,
   output logic [31:0]                       rdata,
   output logic [mem_addr_width-1:0]         mem_addr,
   output logic [3:0]                        mem_wen,
   output logic [31:0]                       mem_wdata,
   input  logic [31:0]                       mem_rdata
);

   // ---------------- request stage ----------------
   logic [NUM_REQ-1:0] w_gnt;
   logic [NUM_REQ-1:0] w_elig;
   logic               w_pick_vld;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [IDX_W-1:0]   w_ptr;
   cmd_t               w_pick_cmd;

   // Access-stage registers
   logic               r_s1_vld;
   cmd_t               r_s1_cmd;

   // Response-stage registers
   logic               r_s2_vld;
   logic [IDX_W-1:0]   r_s2_id;
   logic               r_s2_rd;
   logic               r_s2_oor;

   // Grant is the one-hot decode of the access-stage owner.
   always_comb begin
      w_gnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_gnt[i] = r_s1_vld && (r_s1_cmd.id == IDX_W'(i));
      end
   end

`ifdef BRAM_ARB_LOCK_EN
   logic [NUM_REQ-1:0] w_own_oh;
   logic               w_lock_hold;

   always_comb begin
      w_own_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_own_oh[i] = (w_ptr == IDX_W'(i));
      end
   end

   // A locking owner that is being granted keeps the bus: only it stays
   // eligible and its one-cycle self-mask is waived, so rr_next returns the
   // owner again and the pointer stays put.
   assign w_lock_hold = |(w_own_oh & w_gnt & lock);
   assign w_elig      = w_lock_hold ? (req & w_own_oh) : (req & ~w_gnt);
`else
   // The requester being granted this cycle still holds req at this edge;
   // mask it so the same command is not accepted twice.
   assign w_elig = req & ~w_gnt;
`endif

   bram_rr_pick #(
      .NUM_REQ    (NUM_REQ)
   ) u_pick (
      .clk        (clk),
      .reset      (reset),
      .i_eligible (w_elig),
      .o_vld      (w_pick_vld),
      .o_idx      (w_pick_idx),
      .o_ptr      (w_ptr)
   );

   // Select the winner's command fields out of the packed buses.
   always_comb begin
      w_pick_cmd    = '0;
      w_pick_cmd.id = w_pick_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_idx == IDX_W'(i)) begin
            w_pick_cmd.addr  = MAX_AW'(addr[i*address_width +: address_width]);
            w_pick_cmd.wr    = wr[i*4 +: 4];
            w_pick_cmd.wdata = wdata[i*32 +: 32];
         end
      end
   end

   // ---------------- access stage ----------------
   logic [address_width-1:0] w_addr;
   logic [address_width:0]   w_off;
   logic [address_width:0]   w_room;
   logic                     w_in_range;
   logic                     w_unused;

   assign w_addr = r_s1_cmd.addr[address_width-1:0];

   // Range check via borrow bits: a borrow out of (addr-Base) means below
   // the bank, a borrow out of (End-addr) means above it.
   assign w_off      = {1'b0, w_addr} - {1'b0, BaseAddress};
   assign w_room     = {1'b0, EndAddress} - {1'b0, w_addr};
   assign w_in_range = ~w_off[address_width] & ~w_room[address_width];

   // Word address: rebased offset >> 2, truncated; byte-offset bits ignored.
   assign mem_addr  = (r_s1_vld && w_in_range) ? w_off[mem_addr_width+1:2] : '0;
   assign mem_wen   = (r_s1_vld && w_in_range) ? r_s1_cmd.wr : 4'b0;
   assign mem_wdata = r_s1_cmd.wdata;
   assign gnt       = w_gnt;

   // Bits intentionally not consumed (byte offset, high address bits, the
   // pointer in builds without locking) are folded here.
   assign w_unused = ^{r_s1_cmd.addr, w_off, w_room, w_ptr};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_vld <= 1'b0;
         r_s1_cmd <= '0;
         r_s2_vld <= 1'b0;
         r_s2_id  <= '0;
         r_s2_rd  <= 1'b0;
         r_s2_oor <= 1'b0;
      end else begin
         r_s1_vld <= w_pick_vld;
         if (w_pick_vld) begin
            r_s1_cmd <= w_pick_cmd;
         end
         r_s2_vld <= r_s1_vld;
         r_s2_id  <= r_s1_cmd.id;
         r_s2_rd  <= (r_s1_cmd.wr == 4'b0);
         r_s2_oor <= ~w_in_range;
      end
   end

   // ---------------- response stage ----------------
   always_comb begin
      rvalid = '0;
      err    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_s2_vld && (r_s2_id == IDX_W'(i))) begin
            rvalid[i] = r_s2_rd;
            err[i]    = r_s2_oor;
         end
      end
   end

   // Out-of-range reads return zero; rdata is zero whenever rvalid is idle.
   assign rdata = (r_s2_vld && r_s2_rd && !r_s2_oor) ? mem_rdata : 32'h0;

endmodule
